// File: rtl/uart_tx_arbiter.sv
// Four-lane arbiter feeding one UART transmitter: round-robin or fixed-priority grant, then hold off for frame+guard.
// Latency: ack/tx_valid one cycle after accept; backpressure: requests wait while busy, no grants while en=0.
module uart_tx_arbiter #(
    parameter int FRAME_CYCLES = 104170,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        prio_mode,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [1:0]  last_grant,
    output logic [15:0] tx_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [16:0] CNT_LAST = 17'(FRAME_CYCLES + GAP_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [16:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_ack, w_ack_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic [1:0]  r_last_grant, w_last_grant_nxt;
    logic [15:0] r_tx_count, w_tx_count_nxt;

    logic [1:0]  w_start;
    logic [7:0]  w_req_dbl;
    logic [3:0]  w_req_rot;
    logic [1:0]  w_ofs;
    logic [1:0]  w_win;

    // Rotate the request vector so the search always runs from offset 0.
    assign w_start   = prio_mode ? 2'd0 : r_last_grant + 2'd1;
    assign w_req_dbl = {req, req};
    assign w_req_rot = w_req_dbl[w_start +: 4];
    assign w_win     = w_start + w_ofs;

    always_comb begin
        w_ofs = 2'd3;
        if (w_req_rot[0])      w_ofs = 2'd0;
        else if (w_req_rot[1]) w_ofs = 2'd1;
        else if (w_req_rot[2]) w_ofs = 2'd2;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ack_nxt        = 4'b0000;
        w_tx_valid_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_last_grant_nxt = r_last_grant;
        w_tx_count_nxt   = r_tx_count;
        case (r_state)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    w_state_nxt      = ST_WAIT;
                    w_cnt_nxt        = 17'd0;
                    w_ack_nxt        = 4'b0001 << w_win;
                    w_tx_valid_nxt   = 1'b1;
                    w_tx_data_nxt    = req_data[{w_win, 3'b000} +: 8];
                    w_last_grant_nxt = w_win;
                    w_tx_count_nxt   = r_tx_count + 16'd1;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 17'd1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 17'd0;
            r_ack        <= 4'b0000;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_last_grant <= 2'd3;
            r_tx_count   <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_tx_count   <= w_tx_count_nxt;
        end
    end

    assign ack        = r_ack;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign busy       = (r_state == ST_WAIT);
    assign last_grant = r_last_grant;
    assign tx_count   = r_tx_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 20-cycle frame and 2-cycle guard (accepts 23 cycles apart).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        prio_mode;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  last_grant;
    logic [15:0] tx_count;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_arbiter #(.FRAME_CYCLES(20), .GAP_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prio_mode  (prio_mode),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .last_grant (last_grant),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until an ack pulse appears or the budget runs out.
    task automatic wait_grant(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack == 4'b0000 && cyc < budget);
    endtask

    int  cyc;
    int  n;
    logic seen;
    logic [3:0] exp_ack  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_data [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};

    initial begin
        rst = 1'b1; en = 1'b0; prio_mode = 1'b0; req = 4'b0000; req_data = 32'h0;
        tick(); tick();
        check_eq("rst_ack", ack, 0);
        check_eq("rst_txv", tx_valid, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_last", last_grant, 3);
        check_eq("rst_cnt", tx_count, 0);
        rst = 1'b0;

        // Single lane
        en = 1'b1; req = 4'b0001; req_data = 32'h0000_00A5;
        tick();
        check_eq("single_ack", ack, 4'b0001);
        check_eq("single_txv", tx_valid, 1);
        check_eq("single_data", tx_data, 8'hA5);
        check_eq("single_busy", busy, 1);
        check_eq("single_cnt", tx_count, 1);
        req = 4'b0000;
        n = 1;
        tick();
        check_eq("single_ack_pulse", ack, 0);
        check_eq("single_txv_pulse", tx_valid, 0);
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check_eq("single_busy_len", n, 22);
        check_eq("single_data_hold", tx_data, 8'hA5);

        // Round-robin from a fresh reset
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        prio_mode = 1'b0; req = 4'b1111; req_data = 32'hDDCC_BBAA;
        for (int g = 0; g < 5; g++) begin
            wait_grant(40, cyc);
            check_eq("rr_ack", ack, exp_ack[g]);
            check_eq("rr_data", tx_data, exp_data[g]);
            check_eq("rr_space", cyc, (g == 0) ? 1 : 23);
        end
        check_eq("rr_cnt", tx_count, 5);

        // Fixed priority
        prio_mode = 1'b1; req = 4'b1010;
        for (int g = 0; g < 2; g++) begin
            wait_grant(40, cyc);
            check_eq("fp_ack_l1", ack, 4'b0010);
            check_eq("fp_data_l1", tx_data, 8'hBB);
            check_eq("fp_space", cyc, 23);
        end
        req = 4'b1000;
        wait_grant(40, cyc);
        check_eq("fp_ack_l3", ack, 4'b1000);
        check_eq("fp_data_l3", tx_data, 8'hDD);
        check_eq("fp_last", last_grant, 3);

        // Enable gating
        en = 1'b0; req = 4'b0001; req_data = 32'h0000_0011;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack != 4'b0000) seen = 1'b1;
        end
        check_eq("en_off_noack", seen, 0);
        en = 1'b1;
        wait_grant(5, cyc);
        check_eq("en_on_ack", ack, 4'b0001);
        check_eq("en_on_lat", cyc, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) en = 1'b0;
            tick();
        end
        check_eq("en_drop_busy_len", n, 22);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ack != 4'b0000 || busy) seen = 1'b1;
        end
        check_eq("en_drop_nogrant", seen, 0);

        // Reset in the middle of a frame
        en = 1'b1;
        wait_grant(5, cyc);
        check_eq("mid_ack", ack, 4'b0001);
        for (int i = 0; i < 9; i++) tick();
        check_eq("mid_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cnt", tx_count, 0);
        check_eq("mid_rst_last", last_grant, 3);
        rst = 1'b0;
        wait_grant(5, cyc);
        check_eq("mid_regrant_lat", cyc, 1);
        check_eq("mid_regrant_ack", ack, 4'b0001);
        check_eq("mid_regrant_cnt", tx_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter FRAME_CYCLES, default 104170; clock cycles one UART frame occupies the downstream transmitter (10 bits x 10417).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2; idle guard cycles appended after each frame.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1; enables new grants.
REQ-006 The block SHALL have port prio_mode, input, 1; 0 selects round-robin, 1 selects fixed priority with lane 0 highest.
REQ-007 The block SHALL have port req, input, 4; per-lane send request, held by the requester until its ack.
REQ-008 The block SHALL have port req_data, input, 32; lane i byte at bits [8i+7:8i].
REQ-009 The block SHALL have port ack, output, 4; one-cycle one-hot pulse marking the accepted lane.
REQ-010 The block SHALL have port tx_valid, output, 1; one-cycle pulse to the transmitter's valid input.
REQ-011 The block SHALL have port tx_data, output, 8; byte for the transmitter, stable until the next grant.
REQ-012 The block SHALL have port busy, output, 1; high while a frame plus guard is in progress.
REQ-013 The block SHALL have port last_grant, output, 2; index of the most recently granted lane.
REQ-014 The block SHALL have port tx_count, output, 16; number of grants, wrapping.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and WAIT.
REQ-016 In IDLE with en=1 and req!=0, at the clock edge the block SHALL select winner w and set ack<=onehot(w), tx_valid<=1, tx_data<=req_data lane w, last_grant<=w, tx_count<=tx_count+1, cnt<=0, state<=WAIT.
REQ-017 Round-robin mode SHALL search lanes starting at (last_grant+1) mod 4 and take the first lane with req set.
REQ-018 Fixed-priority mode SHALL take the lowest-index lane with req set.
REQ-019 ack and tx_valid SHALL be registered and high for exactly one cycle, the cycle after the accepting edge.
REQ-020 In IDLE with en=0 or req=0, the block SHALL hold all registers, with ack=0 and tx_valid=0.
REQ-021 In WAIT, cnt (17 bits) SHALL increment by 1 each cycle.
REQ-022 In WAIT, when cnt==FRAME_CYCLES+GAP_CYCLES-1 the block SHALL return to IDLE at that edge.
REQ-023 The next acceptance SHALL therefore be no earlier than FRAME_CYCLES+GAP_CYCLES+1 cycles after the previous one.
REQ-024 busy SHALL equal (state==WAIT); it is high in the tx_valid cycle.
REQ-025 req SHALL be ignored throughout WAIT, so a requester still asserting req in the ack cycle is not granted twice.
REQ-026 Deasserting en during WAIT SHALL NOT abort the frame; WAIT completes and no new grant follows while en=0.
REQ-027 Changing prio_mode SHALL take effect at the next IDLE decision only.
REQ-028 tx_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 FRAME_CYCLES+GAP_CYCLES SHALL be at most 131072.

Reset
REQ-030 When rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, ack=0, tx_valid=0, tx_data=8'h00, busy=0, tx_count=0, last_grant=2'd3 (first round-robin winner is lane 0).
REQ-031 rst SHALL take priority over all other inputs, including mid-WAIT, where the frame timing is discarded.

Verification (FRAME_CYCLES=20, GAP_CYCLES=2)
REQ-032 The bench SHALL check reset: assert rst 2 cycles -> all outputs zero, last_grant=3, busy=0.
REQ-033 The bench SHALL check a single lane: req=4'b0001, lane0=8'hA5 -> next cycle ack=0001, tx_valid=1, tx_data=A5; busy high 22 cycles; tx_count=1.
REQ-034 The bench SHALL check round-robin: req=4'b1111 held, prio_mode=0 -> grants on lanes 0,1,2,3,0, accepts spaced 23 cycles apart.
REQ-035 The bench SHALL check fixed priority: prio_mode=1, req=4'b1010 held -> lane1 granted repeatedly; after lane1 drops, lane3 granted.
REQ-036 The bench SHALL check en: en=0 with req=0001 -> no ack for 50 cycles; en=1 -> grant; drop en at WAIT cycle 5 -> busy completes all 22 cycles, then no grant.
REQ-037 The bench SHALL check reset mid-frame: rst at WAIT cycle 10 -> next cycle busy=0, tx_count=0; with req=0001 held, grant occurs 1 cycle after rst releases.
